// File: rtl/muldiv_hilo_unit_if.sv
// muldiv_hilo_unit_if: request/MT-write/status bundle for the mul/div HI/LO unit
//   master drives start/op/cancel/a/b/hi_we/lo_we/wdata; slave drives busy/done/hi/lo
interface muldiv_hilo_unit_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic hi_we;
  logic lo_we;
  logic [WIDTH-1:0] wdata;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, cancel, a, b, hi_we, lo_we, wdata, input busy, done, hi, lo);
  modport slave(input start, op, cancel, a, b, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative radix-2 MULT/MULTU/DIV/DIVU engine with HI/LO registers
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   io   slave side: start/op/cancel/a/b request, hi_we/lo_we/wdata MT writes,
//        busy/done status, hi/lo register outputs
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
  input logic clk,
  input logic rst,
  muldiv_hilo_unit_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] FIX = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, mq, md, hi_q, lo_q;
  logic is_div, neg_p, neg_r, dz, done_q;
  logic sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0] sum, sh;
  logic ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  // Operands are run as magnitudes; the signs are reapplied in FIX.
  always_comb begin
    sa = io.op[0] & io.a[WIDTH-1];
    sb = io.op[0] & io.b[WIDTH-1];
    abs_a = sa ? -io.a : io.a;
    abs_b = sb ? -io.b : io.b;
    sum = {1'b0, acc} + (mq[0] ? {1'b0, md} : '0);
    sh = {acc, mq[WIDTH-1]};
    ge = sh >= {1'b0, md};
    prod = {acc, mq};
    prod_fix = neg_p ? -prod : prod;
    fix_hi = is_div ? (neg_r ? -acc : acc) : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? (dz ? '1 : (neg_p ? -mq : mq)) : prod_fix[WIDTH-1:0];
  end
  // acc holds the running high product / partial remainder, mq the multiplier / quotient.
  // A zero divisor makes every restoring step succeed, so acc ends up as |a|.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mq <= '0;
      md <= '0;
      hi_q <= HILO_RESET;
      lo_q <= HILO_RESET;
      is_div <= 1'b0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (io.hi_we) hi_q <= io.wdata;
        if (io.lo_we) lo_q <= io.wdata;
        if (io.start && !io.cancel) begin
          state <= RUN;
          cnt <= CW'(WIDTH);
          acc <= '0;
          mq <= abs_a;
          md <= abs_b;
          is_div <= io.op[1];
          neg_p <= sa ^ sb;
          neg_r <= sa;
          dz <= io.b == '0;
        end
      end else if (io.cancel) begin
        state <= IDLE;
      end else if (state == RUN) begin
        acc <= is_div ? (ge ? sh[WIDTH-1:0] - md : sh[WIDTH-1:0]) : sum[WIDTH:1];
        mq <= is_div ? {mq[WIDTH-2:0], ge} : {sum[0], mq[WIDTH-1:1]};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) state <= FIX;
      end else begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
        done_q <= 1'b1;
        state <= IDLE;
      end
    end
  end
  assign io.busy = state != IDLE;
  assign io.done = done_q;
  assign io.hi = hi_q;
  assign io.lo = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: random + directed self-checking bench against a transaction-level model
module tb_muldiv_hilo_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  muldiv_hilo_unit_if #(W) bus ();
  muldiv_hilo_unit #(.WIDTH(W), .HILO_RESET('0)) dut (.clk(clk), .rst(rst_n), .io(bus));
  always #5 clk = ~clk;
  bit m_busy, m_done;
  int m_rem;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Arithmetic reference: plain 64-bit integer math from the instruction definitions.
  function automatic void calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b00) begin
      p = {32'd0, a} * {32'd0, b};
      {h, l} = p;
    end else if (op == 2'b01) begin
      p = sa * sb;
      {h, l} = p;
    end else if (b == 0) begin
      h = a;
      l = '1;
    end else if (op == 2'b10) begin
      l = a / b;
      h = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[W-1:0];
      h = r[W-1:0];
    end
  endfunction
  // Transaction model: a result computed at acceptance appears WIDTH+1 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_done = 0;
      m_rem = 0;
      m_hi = '0;
      m_lo = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (bus.cancel) m_busy = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = p_hi;
            m_lo = p_lo;
            m_busy = 0;
            m_done = 1;
          end
        end
      end else begin
        if (bus.hi_we) m_hi = bus.wdata;
        if (bus.lo_we) m_lo = bus.wdata;
        if (bus.start && !bus.cancel) begin
          calc(bus.op, bus.a, bus.b, p_hi, p_lo);
          m_busy = 1;
          m_rem = W + 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_busy", {31'd0, bus.busy}, {31'd0, m_busy});
      chk("model_done", {31'd0, bus.done}, {31'd0, m_done});
      chk("model_hi", bus.hi, m_hi);
      chk("model_lo", bus.lo, m_lo);
    end
  end
  task automatic idle();
    bus.start = 0;
    bus.cancel = 0;
    bus.hi_we = 0;
    bus.lo_we = 0;
  endtask
  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'd1;
      4: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction
  // Called at a negedge: issues the op, then waits for done, counting busy cycles.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
    bus.start = 1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.start = 0;
      bus.a = 32'($urandom);
      bus.b = 32'($urandom);
      if (bus.busy) cyc++;
      if (bus.done) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL done_timeout: got no done expected done within 100 cycles");
  endtask
  initial begin
    logic [W-1:0] h, l;
    int cyc;
    idle();
    bus.op = 0;
    bus.a = 0;
    bus.b = 0;
    bus.wdata = 0;
    calc(2'b01, 32'hFFFF_FFFD, 32'd5, h, l);
    chk("pin_mult_hi", h, 32'hFFFF_FFFF);
    chk("pin_mult_lo", l, 32'hFFFF_FFF1);
    calc(2'b11, 32'hFFFF_FFF9, 32'd2, h, l);
    chk("pin_div_lo", l, 32'hFFFF_FFFD);
    chk("pin_div_hi", h, 32'hFFFF_FFFF);
    calc(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
    chk("pin_divmin_lo", l, 32'h8000_0000);
    chk("pin_divmin_hi", h, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, cyc);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFF1);
    chk("mult_busy_cycles", 32'(cyc), 32'd33);
    @(negedge clk);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    chk("multu_busy_cycles", 32'(cyc), 32'd33);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("b2b_div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("b2b_div_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("divu_lo", bus.lo, 32'h7FFF_FFFC);
    chk("divu_hi", bus.hi, 32'h1);
    run_op(2'b10, 32'd7, 32'd0, cyc);
    chk("divu0_hi", bus.hi, 32'h7);
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, cyc);
    chk("div0_hi", bus.hi, 32'hFFFF_FFF9);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("divmin_lo", bus.lo, 32'h8000_0000);
    chk("divmin_hi", bus.hi, 32'h0);
    @(negedge clk);
    bus.hi_we = 1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 0;
    chk("mthi", bus.hi, 32'h1234);
    bus.start = 1;
    bus.op = 2'b01;
    bus.a = 32'd9;
    bus.b = 32'd9;
    @(negedge clk);
    bus.start = 0;
    repeat (9) @(negedge clk);
    bus.cancel = 1;
    @(negedge clk);
    bus.cancel = 0;
    chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
    chk("cancel_done", {31'd0, bus.done}, 32'd0);
    repeat (40) @(negedge clk);
    chk("cancel_hi", bus.hi, 32'h1234);
    bus.start = 1;
    bus.cancel = 1;
    @(negedge clk);
    idle();
    chk("start_cancel_idle", {31'd0, bus.busy}, 32'd0);
    bus.start = 1;
    bus.op = 2'b11;
    bus.a = 32'd100;
    bus.b = 32'd3;
    @(negedge clk);
    bus.start = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = ($urandom % 4) == 0;
      bus.cancel = ($urandom % 64) == 0;
      bus.hi_we = ($urandom % 8) == 0;
      bus.lo_we = ($urandom % 8) == 0;
      bus.op = 2'($urandom);
      bus.a = pick();
      bus.b = pick();
      bus.wdata = 32'($urandom);
    end
    @(negedge clk);
    idle();
    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
